// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags; shifts iterate one bit per cycle.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
`timescale 1ns/1ps
module alu_seq #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   ALU_op_code,
    input  logic [W-1:0] ALU_arg_0,
    input  logic [W-1:0] ALU_arg_1,
    input  logic         SC_IN,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] ALU_out,
    output logic         SC_OUT,
    output logic         ZERO,
    output logic         BEVEN,
    output logic         PARITY,
    output logic         EQUAL,
    output logic         GT
);
    localparam int CW = $clog2(W + 1);
    localparam logic [2:0] OP_ADD = 3'b000, OP_LSL = 3'b001, OP_XOR = 3'b010, OP_AND = 3'b011,
                           OP_CMP = 3'b100, OP_SET = 3'b101, OP_LSR = 3'b110, OP_SUB = 3'b111;
    localparam logic [W-1:0]  W_MAX   = W'(W);
    localparam logic [CW-1:0] AMT_MAX = CW'(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef struct packed {
        logic sc;
        logic zero;
        logic beven;
        logic parity;
        logic equal;
        logic gt;
    } flags_t;

    state_t       state_q, state_d;
    logic [W-1:0] res_q, res_d;
    flags_t       flg_q, flg_d;

    logic          accept;
    logic [CW-1:0] amt;
    logic [W:0]    sum;
    logic [W-1:0]  imm_res;
    logic          imm_sc;
    logic          op_par, op_eq, op_gt;

`ifdef ALU_FAST_SHIFT_EN
    logic [W:0] lsl_ext, lsr_ext;
`else
    logic [W-1:0]  work_q, work_d, step;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lsl_q, lsl_d, step_sc, is_shift;
    logic [2:0]    pend_q, pend_d;   // parity/equal/gt captured at accept
`endif

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign ALU_out   = res_q;
    assign {SC_OUT, ZERO, BEVEN, PARITY, EQUAL, GT} = flg_q;

    assign amt    = (ALU_arg_1 > W_MAX) ? AMT_MAX : ALU_arg_1[CW-1:0];
    assign op_par = ^ALU_arg_1;
    assign op_eq  = (ALU_arg_0 == ALU_arg_1);
    assign op_gt  = (ALU_arg_1 > ALU_arg_0);

    // Single-cycle result for everything that completes at the accept edge
    always_comb begin
        sum     = {1'b0, ALU_arg_0} + {1'b0, ALU_arg_1} + {{W{1'b0}}, SC_IN};
        imm_res = '0;
        imm_sc  = 1'b0;
`ifdef ALU_FAST_SHIFT_EN
        lsl_ext = {1'b0, ALU_arg_0} << amt;
        lsr_ext = {ALU_arg_0, 1'b0} >> amt;
`endif
        case (ALU_op_code)
            OP_ADD: begin imm_res = sum[W-1:0]; imm_sc = sum[W]; end
`ifdef ALU_FAST_SHIFT_EN
            OP_LSL: begin imm_res = lsl_ext[W-1:0]; imm_sc = lsl_ext[W]; end
            OP_LSR: begin imm_res = lsr_ext[W:1];   imm_sc = lsr_ext[0]; end
`else
            OP_LSL, OP_LSR: imm_res = ALU_arg_0;   // only taken with amt == 0
`endif
            OP_XOR: imm_res = ALU_arg_0 ^ ALU_arg_1;
            OP_AND: imm_res = ALU_arg_0 & ALU_arg_1;
            OP_CMP: imm_res = '0;
            OP_SET: imm_res = ALU_arg_1;
            OP_SUB: begin imm_res = ALU_arg_0 - ALU_arg_1; imm_sc = op_gt; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        flg_d   = flg_q;
`ifndef ALU_FAST_SHIFT_EN
        work_d   = work_q;
        cnt_d    = cnt_q;
        lsl_d    = lsl_q;
        pend_d   = pend_q;
        is_shift = (ALU_op_code == OP_LSL) || (ALU_op_code == OP_LSR);
        step     = lsl_q ? {work_q[W-2:0], 1'b0} : {1'b0, work_q[W-1:1]};
        step_sc  = lsl_q ? work_q[W-1] : work_q[0];
`endif
        if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
            if (is_shift && (amt != '0)) begin
                state_d = SHIFT;
                work_d  = ALU_arg_0;
                cnt_d   = amt;
                lsl_d   = (ALU_op_code == OP_LSL);
                pend_d  = {op_par, op_eq, op_gt};
            end else
`endif
            begin
                state_d = DONE;
                res_d   = imm_res;
                flg_d   = {imm_sc, (imm_res == '0), ~imm_res[0], op_par, op_eq, op_gt};
            end
        end else if ((state_q == DONE) && out_ready) begin
            state_d = IDLE;
        end
`ifndef ALU_FAST_SHIFT_EN
        else if (state_q == SHIFT) begin
            work_d = step;
            cnt_d  = cnt_q - CW'(1);
            // Outputs only move on the completing step so ALU_out stays stable meanwhile
            if (cnt_q == CW'(1)) begin
                state_d = DONE;
                res_d   = step;
                flg_d   = {step_sc, (step == '0), ~step[0], pend_q};
            end
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            flg_q   <= '0;
`ifndef ALU_FAST_SHIFT_EN
            work_q  <= '0;
            cnt_q   <= '0;
            lsl_q   <= 1'b0;
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
`ifndef ALU_FAST_SHIFT_EN
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            lsl_q   <= lsl_d;
            pend_q  <= pend_d;
`endif
        end
    end
endmodule
